// File: rtl/fnd_pkg.sv
// fnd_pkg: shared segment/digit-enable constants, digit codes and FSM states for the FND driver
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [3:0] COM_DIG0 = 4'b1110;
    localparam logic [3:0] COM_DIG1 = 4'b1101;
    localparam logic [3:0] COM_DIG2 = 4'b1011;
    localparam logic [3:0] COM_DIG3 = 4'b0111;

    typedef logic [3:0] digit_t;
    localparam digit_t DIG_BLANK = 4'hA;
    localparam digit_t DIG_DASH  = 4'hB;

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    function automatic logic [7:0] seg_of(input digit_t d);
        case (d)
            4'd0:      return SEG_0;
            4'd1:      return SEG_1;
            4'd2:      return SEG_2;
            4'd3:      return SEG_3;
            4'd4:      return SEG_4;
            4'd5:      return SEG_5;
            4'd6:      return SEG_6;
            4'd7:      return SEG_7;
            4'd8:      return SEG_8;
            4'd9:      return SEG_9;
            DIG_DASH:  return SEG_DASH;
            default:   return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [3:0] com_of(input logic [1:0] s);
        return s == 2'd0 ? COM_DIG0 : s == 2'd1 ? COM_DIG1 : s == 2'd2 ? COM_DIG2 : COM_DIG3;
    endfunction

endpackage

// File: rtl/fnd_scan_driver_bin2bcd_seq.sv
// bin2bcd_seq: 14-iteration sequential double-dabble, binary to 4-digit BCD
module bin2bcd_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    logic [29:0] r_sh;
    logic [3:0]  r_cnt;
    logic        r_busy;
    logic [15:0] w_adj;
    logic [29:0] w_next;

    for (genvar g = 0; g < 4; g++) begin : g_adj
        assign w_adj[g*4 +: 4] = r_sh[14+g*4 +: 4] >= 4'd5 ? r_sh[14+g*4 +: 4] + 4'd3 : r_sh[14+g*4 +: 4];
    end

    assign w_next = {w_adj, r_sh[13:0]} << 1;

    // load on start, then one add-3/shift step per cycle for 14 cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (start && !r_busy) begin
            r_sh   <= {16'd0, bin};
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_sh   <= w_next;
            r_cnt  <= r_cnt + 4'd1;
            r_busy <= r_cnt != 4'd13;
        end
    end

    assign busy = r_busy;
    assign done = r_busy && r_cnt == 4'd13;
    assign bcd  = r_sh[29:14];

endmodule

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: stable-sample capture, BCD conversion and 4-digit multiplexed 7-segment scan
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int F_SYS      = 100_000_000,
    parameter int F_SCAN     = 1_000,
    parameter int BLANK_LEAD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] count_data,
    output logic [7:0]  fnd_data,
    output logic [3:0]  fnd_com,
    output logic        conv_busy
);

    localparam int TC = F_SYS / F_SCAN - 1;
    localparam int PW = TC > 0 ? $clog2(TC + 1) : 1;

    state_t          r_state, w_next_state;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_sel;
    logic [7:0]      r_fnd_data;
    logic [3:0]      r_fnd_com;
    logic [13:0]     r_s_now, r_s_prev, r_cap, r_last;
    logic [1:0]      r_sv;
    logic            r_have;
    digit_t [3:0]    r_disp, w_digits;
    logic [3:0]      w_lz;
    logic [15:0]     w_bcd;
    logic            w_tick, w_stable, w_ovf, w_start, w_done, w_busy;

    assign w_tick   = r_presc == PW'(TC);
    assign w_ovf    = r_s_now > 14'd9999;
    assign w_stable = r_sv[1] && r_s_now == r_s_prev && (!r_have || r_s_now != r_last);

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .bin   (r_s_now),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    assign w_lz[3] = w_bcd[15:12] == 4'd0;
    assign w_lz[2] = w_lz[3] && w_bcd[11:8] == 4'd0;
    assign w_lz[1] = w_lz[2] && w_bcd[7:4] == 4'd0;
    assign w_lz[0] = 1'b0;

    for (genvar g = 0; g < 4; g++) begin : g_dig
        assign w_digits[g] = r_cap > 14'd9999 ? DIG_DASH :
                             (BLANK_LEAD != 0 && w_lz[g]) ? DIG_BLANK : w_bcd[g*4 +: 4];
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // capture a stable new value; out-of-range values skip straight to LOAD
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            IDLE: if (w_stable) begin
                w_next_state = w_ovf ? LOAD : CONV;
                w_start      = !w_ovf;
            end
            CONV:    w_next_state = w_done ? LOAD : CONV;
            LOAD:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // two-deep sampling of the foreign-domain count, capture and display update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s_now  <= '0;
            r_s_prev <= '0;
            r_sv     <= '0;
            r_cap    <= '0;
            r_last   <= '0;
            r_have   <= 1'b0;
            r_disp   <= {4{DIG_BLANK}};
        end else begin
            r_s_now  <= count_data;
            r_s_prev <= r_s_now;
            r_sv     <= {r_sv[0], 1'b1};
            if (r_state == IDLE && w_stable) r_cap <= r_s_now;
            if (r_state == LOAD) begin
                r_last <= r_cap;
                r_have <= 1'b1;
                r_disp <= w_digits;
            end
        end
    end

    // prescaler tick advances the digit select and refreshes the registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc    <= '0;
            r_sel      <= '0;
            r_fnd_data <= SEG_BLANK;
            r_fnd_com  <= 4'b1111;
        end else if (w_tick) begin
            r_presc    <= '0;
            r_sel      <= r_sel + 2'd1;
            r_fnd_data <= seg_of(r_disp[r_sel]);
            r_fnd_com  <= com_of(r_sel);
        end else begin
            r_presc    <= r_presc + PW'(1);
        end
    end

    assign fnd_data  = r_fnd_data;
    assign fnd_com   = r_fnd_com;
    assign conv_busy = w_busy;

endmodule
